// File: rtl/outer_wb_scheduler_if.sv
// Wishbone link bundle for the outer 16-bit bus: one requester/target pair.
// The master modport drives the request; the slave modport answers it.
interface outer_wb_scheduler_if #(
    parameter int ADDR_W = 24
);
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [15:0]       wb_o_dat;
    logic [1:0]        wb_sel;
    logic              wb_4_burst;
    logic              wb_8_burst;
    logic              wb_ack;
    logic              wb_err;
    logic [15:0]       wb_i_dat;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst,
        input  wb_ack, wb_err, wb_i_dat
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel, wb_4_burst, wb_8_burst,
        output wb_ack, wb_err, wb_i_dat
    );
endinterface

// File: rtl/outer_wb_scheduler.sv
// Round-robin scheduler sharing the outer Wishbone port between m0 (SPI) and m1 (inner bus).
// Define WB_TIMEOUT_EN to build the per-beat watchdog that ends hung beats with err.
//   state | meaning
//   IDLE  | no owner, arbitrate on cyc
//   OWN0  | m0 owns the bus until its cyc drops
//   OWN1  | m1 owns the bus until its cyc drops
module outer_wb_scheduler #(
    parameter int WB_ADDR_W = 24,
    parameter int TIMEOUT   = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    outer_wb_scheduler_if.slave         m0,
    outer_wb_scheduler_if.slave         m1,
    outer_wb_scheduler_if.master        s,
    output logic [1:0]                  o_grant,
    output logic                        o_timeout
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;

    logic                 own0, own1;
    logic                 own_cyc, own_stb, own_we, own_b4, own_b8;
    logic [WB_ADDR_W-1:0] own_adr;
    logic [15:0]          own_dat;
    logic [1:0]           own_sel;
    logic                 raw_stb;
    logic                 expire;
    logic                 fire;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            last  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // last holds the index of the most recently granted master
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0.wb_cyc && m1.wb_cyc) begin
                    if (last) begin
                        state_nxt = OWN0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = OWN1;
                        last_nxt  = 1'b1;
                    end
                end else if (m0.wb_cyc) begin
                    state_nxt = OWN0;
                    last_nxt  = 1'b0;
                end else if (m1.wb_cyc) begin
                    state_nxt = OWN1;
                    last_nxt  = 1'b1;
                end
            end
            OWN0:    if (!m0.wb_cyc) state_nxt = IDLE;
            OWN1:    if (!m1.wb_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign own0    = (state == OWN0);
    assign own1    = (state == OWN1);
    assign o_grant = {own1, own0};

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_b4  = 1'b0;
        own_b8  = 1'b0;
        if (own0) begin
            own_cyc = m0.wb_cyc;
            own_stb = m0.wb_stb;
            own_we  = m0.wb_we;
            own_adr = m0.wb_adr;
            own_dat = m0.wb_o_dat;
            own_sel = m0.wb_sel;
            own_b4  = m0.wb_4_burst;
            own_b8  = m0.wb_8_burst;
        end else if (own1) begin
            own_cyc = m1.wb_cyc;
            own_stb = m1.wb_stb;
            own_we  = m1.wb_we;
            own_adr = m1.wb_adr;
            own_dat = m1.wb_o_dat;
            own_sel = m1.wb_sel;
            own_b4  = m1.wb_4_burst;
            own_b8  = m1.wb_8_burst;
        end
    end

    assign raw_stb = own_cyc & own_stb;

`ifdef WB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // stb masking keys off the registered count only, so there is no loop through the target's ack
    assign expire = raw_stb && (wd_cnt == 16'(TIMEOUT));
    assign fire   = expire & ~s.wb_ack & ~s.wb_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wd_cnt <= 16'd0;
        end else if (!raw_stb || s.wb_ack || s.wb_err || expire) begin
            wd_cnt <= 16'd0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign expire = 1'b0;
    assign fire   = 1'b0;
`endif

    assign o_timeout = fire;

    assign s.wb_cyc     = own_cyc;
    assign s.wb_stb     = raw_stb & ~expire;
    assign s.wb_we      = own_we;
    assign s.wb_adr     = own_adr;
    assign s.wb_o_dat   = own_dat;
    assign s.wb_sel     = own_sel;
    assign s.wb_4_burst = own_b4;
    assign s.wb_8_burst = own_b8;

    assign m0.wb_ack   = own0 & s.wb_ack;
    assign m0.wb_err   = own0 & (s.wb_err | fire);
    assign m0.wb_i_dat = s.wb_i_dat;
    assign m1.wb_ack   = own1 & s.wb_ack;
    assign m1.wb_err   = own1 & (s.wb_err | fire);
    assign m1.wb_i_dat = s.wb_i_dat;
endmodule

// File: tb/tb_outer_wb_scheduler.sv
// Directed bench for outer_wb_scheduler; inputs change #1 after posedge, outputs sampled on negedge.
// Watchdog scenarios follow WB_TIMEOUT_EN the same way the design does.
module tb_outer_wb_scheduler;
    logic       clk;
    logic       rst_n;
    logic [1:0] grant;
    logic       timeout;
    int         checks;
    int         errors;

    outer_wb_scheduler_if #(.ADDR_W(24)) m0_if ();
    outer_wb_scheduler_if #(.ADDR_W(24)) m1_if ();
    outer_wb_scheduler_if #(.ADDR_W(24)) s_if ();

    outer_wb_scheduler #(.WB_ADDR_W(24), .TIMEOUT(4)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .o_grant   (grant),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        m0_if.wb_cyc = 0; m0_if.wb_stb = 0; m0_if.wb_we = 0; m0_if.wb_adr = '0;
        m0_if.wb_o_dat = '0; m0_if.wb_sel = '0; m0_if.wb_4_burst = 0; m0_if.wb_8_burst = 0;
        m1_if.wb_cyc = 0; m1_if.wb_stb = 0; m1_if.wb_we = 0; m1_if.wb_adr = '0;
        m1_if.wb_o_dat = '0; m1_if.wb_sel = '0; m1_if.wb_4_burst = 0; m1_if.wb_8_burst = 0;
        s_if.wb_ack = 0; s_if.wb_err = 0; s_if.wb_i_dat = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive_idle();
        m0_if.wb_cyc = 1; m0_if.wb_stb = 1; m0_if.wb_adr = 24'h00ABCD; m0_if.wb_sel = 2'b11;
        s_if.wb_ack = 1;
        tick(); tick();
        sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
        checks++; if (s_if.wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc got %b want 0", s_if.wb_cyc); end
        checks++; if (s_if.wb_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb got %b want 0", s_if.wb_stb); end
        checks++; if (s_if.wb_adr !== 24'h0) begin errors++; $display("FAIL reset_s_adr got %h want 0", s_if.wb_adr); end
        checks++; if (s_if.wb_sel !== 2'b00) begin errors++; $display("FAIL reset_s_sel got %b want 00", s_if.wb_sel); end
        checks++; if (m0_if.wb_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack got %b want 0", m0_if.wb_ack); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
        tick();
        rst_n = 1;
        drive_idle();
        sample();
    endtask

    task automatic test_tie();
        tick();
        m0_if.wb_cyc = 1; m0_if.wb_stb = 1; m0_if.wb_adr = 24'h000100;
        m1_if.wb_cyc = 1; m1_if.wb_stb = 1; m1_if.wb_adr = 24'h000200;
        sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_c0_grant got %b want 00", grant); end
        tick(); sample();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_first_grant got %b want 10", grant); end
        checks++; if (s_if.wb_adr !== 24'h000200) begin errors++; $display("FAIL tie_s_adr got %h want 000200", s_if.wb_adr); end
        tick();
        s_if.wb_ack = 1; s_if.wb_i_dat = 16'h1234;
        sample();
        checks++; if (m1_if.wb_ack !== 1'b1) begin errors++; $display("FAIL tie_m1_ack got %b want 1", m1_if.wb_ack); end
        checks++; if (m0_if.wb_ack !== 1'b0) begin errors++; $display("FAIL tie_m0_ack got %b want 0", m0_if.wb_ack); end
        tick();
        s_if.wb_ack = 0; m1_if.wb_cyc = 0; m1_if.wb_stb = 0;
        sample();
        checks++; if (s_if.wb_cyc !== 1'b0) begin errors++; $display("FAIL tie_release_s_cyc got %b want 0", s_if.wb_cyc); end
        tick(); sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle_gap got %b want 00", grant); end
        tick(); sample();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_second_grant got %b want 01", grant); end
        checks++; if (s_if.wb_adr !== 24'h000100) begin errors++; $display("FAIL tie_second_adr got %h want 000100", s_if.wb_adr); end
        tick(); drive_idle();
        tick(); sample();
    endtask

    task automatic test_single();
        tick();
        m1_if.wb_cyc = 1; m1_if.wb_stb = 1; m1_if.wb_adr = 24'h001010; m1_if.wb_sel = 2'b11;
        sample();
        checks++; if (s_if.wb_cyc !== 1'b0) begin errors++; $display("FAIL single_c0_s_cyc got %b want 0", s_if.wb_cyc); end
        tick(); sample();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL single_grant got %b want 10", grant); end
        checks++; if (s_if.wb_cyc !== 1'b1) begin errors++; $display("FAIL single_s_cyc got %b want 1", s_if.wb_cyc); end
        checks++; if (s_if.wb_adr !== 24'h001010) begin errors++; $display("FAIL single_s_adr got %h want 001010", s_if.wb_adr); end
        tick();
        tick();
        s_if.wb_ack = 1; s_if.wb_i_dat = 16'hBEEF;
        sample();
        checks++; if (m1_if.wb_ack !== 1'b1) begin errors++; $display("FAIL single_m1_ack got %b want 1", m1_if.wb_ack); end
        checks++; if (m1_if.wb_i_dat !== 16'hBEEF) begin errors++; $display("FAIL single_m1_dat got %h want BEEF", m1_if.wb_i_dat); end
        checks++; if (m0_if.wb_ack !== 1'b0) begin errors++; $display("FAIL single_m0_ack got %b want 0", m0_if.wb_ack); end
        tick(); drive_idle();
        tick(); sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_end_grant got %b want 00", grant); end
    endtask

    task automatic test_burst();
        int acks0;
        acks0 = 0;
        tick();
        m0_if.wb_cyc = 1; m0_if.wb_stb = 1; m0_if.wb_8_burst = 1; m0_if.wb_adr = 24'h002000;
        m1_if.wb_cyc = 1; m1_if.wb_stb = 1; m1_if.wb_adr = 24'h003000;
        sample();
        for (int i = 1; i <= 8; i++) begin
            tick();
            s_if.wb_ack = 1;
            sample();
            if (m0_if.wb_ack === 1'b1) acks0++;
            checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_grant beat %0d got %b want 01", i, grant); end
            checks++; if (m1_if.wb_ack !== 1'b0) begin errors++; $display("FAIL burst_m1_ack beat %0d got %b want 0", i, m1_if.wb_ack); end
            if (i == 1) begin
                checks++; if (s_if.wb_8_burst !== 1'b1) begin errors++; $display("FAIL burst_flag got %b want 1", s_if.wb_8_burst); end
            end
        end
        tick();
        m0_if.wb_cyc = 0; m0_if.wb_stb = 0; m0_if.wb_8_burst = 0; s_if.wb_ack = 0;
        sample();
        checks++; if (acks0 != 8) begin errors++; $display("FAIL burst_ack_count got %0d want 8", acks0); end
        checks++; if (s_if.wb_cyc !== 1'b0) begin errors++; $display("FAIL burst_release_cyc got %b want 0", s_if.wb_cyc); end
        tick(); sample();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_gap got %b want 00", grant); end
        tick(); sample();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_m1_grant got %b want 10", grant); end
        tick(); drive_idle();
        tick(); sample();
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        exp = 2'b01;
        tick();
        m0_if.wb_cyc = 1; m0_if.wb_stb = 1;
        m1_if.wb_cyc = 1; m1_if.wb_stb = 1;
        for (int t = 0; t < 10; t++) begin
            sample();
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fair_idle t%0d got %b want 00", t, grant); end
            tick();
            s_if.wb_ack = 1;
            sample();
            checks++; if (grant !== exp) begin errors++; $display("FAIL fair_grant t%0d got %b want %b", t, grant, exp); end
            checks++; if ({m1_if.wb_ack, m0_if.wb_ack} !== exp) begin errors++; $display("FAIL fair_ack t%0d got %b want %b", t, {m1_if.wb_ack, m0_if.wb_ack}, exp); end
            tick();
            tick();
            s_if.wb_ack = 0;
            if (exp == 2'b01) m0_if.wb_cyc = 0; else m1_if.wb_cyc = 0;
            sample();
            checks++; if (s_if.wb_cyc !== 1'b0) begin errors++; $display("FAIL fair_release t%0d got %b want 0", t, s_if.wb_cyc); end
            tick();
            m0_if.wb_cyc = 1; m1_if.wb_cyc = 1;
            exp = ~exp;
        end
        drive_idle();
        tick(); tick(); sample();
    endtask

    task automatic test_watchdog();
        int pulses;
        pulses = 0;
        tick();
        m0_if.wb_cyc = 1; m0_if.wb_stb = 1; m0_if.wb_adr = 24'h004000;
`ifdef WB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) m0_if.wb_stb = 0;
            sample();
            if (timeout === 1'b1) pulses++;
            checks++; if (s_if.wb_stb !== (k < 5)) begin errors++; $display("FAIL wd_s_stb cycle %0d got %b want %b", k, s_if.wb_stb, (k < 5)); end
            checks++; if (m0_if.wb_err !== (k == 5)) begin errors++; $display("FAIL wd_m0_err cycle %0d got %b want %b", k, m0_if.wb_err, (k == 5)); end
            checks++; if (timeout !== (k == 5)) begin errors++; $display("FAIL wd_pulse cycle %0d got %b want %b", k, timeout, (k == 5)); end
            checks++; if (m1_if.wb_err !== 1'b0) begin errors++; $display("FAIL wd_m1_err cycle %0d got %b want 0", k, m1_if.wb_err); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL wd_pulse_count got %0d want 1", pulses); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_grant_kept got %b want 01", grant); end
        for (int j = 0; j < 4; j++) begin
            tick();
            m0_if.wb_stb = 1;
            sample();
            checks++; if (s_if.wb_stb !== 1'b1) begin errors++; $display("FAIL wd_retry_stb %0d got %b want 1", j, s_if.wb_stb); end
        end
        tick();
        s_if.wb_ack = 1;
        sample();
        checks++; if (m0_if.wb_ack !== 1'b1) begin errors++; $display("FAIL wd_tie_ack got %b want 1", m0_if.wb_ack); end
        checks++; if (m0_if.wb_err !== 1'b0) begin errors++; $display("FAIL wd_tie_err got %b want 0", m0_if.wb_err); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_tie_pulse got %b want 0", timeout); end
`else
        for (int k = 1; k <= 20; k++) begin
            tick(); sample();
            if (timeout === 1'b1) pulses++;
            checks++; if (s_if.wb_stb !== 1'b1) begin errors++; $display("FAIL nowd_s_stb cycle %0d got %b want 1", k, s_if.wb_stb); end
            checks++; if (m0_if.wb_err !== 1'b0) begin errors++; $display("FAIL nowd_m0_err cycle %0d got %b want 0", k, m0_if.wb_err); end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL nowd_pulse_count got %0d want 0", pulses); end
`endif
        tick(); drive_idle();
        tick(); tick(); sample();
    endtask

    task automatic test_reset_mid();
        tick();
        m0_if.wb_cyc = 1; m0_if.wb_stb = 1; m0_if.wb_adr = 24'h005000;
        tick(); sample();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_grant got %b want 01", grant); end
        tick();
        rst_n = 0;
        sample();
        checks++; if (s_if.wb_cyc !== 1'b1) begin errors++; $display("FAIL rmid_sync_hold got %b want 1", s_if.wb_cyc); end
        tick();
        s_if.wb_ack = 1;
        sample();
        checks++; if (s_if.wb_cyc !== 1'b0) begin errors++; $display("FAIL rmid_s_cyc got %b want 0", s_if.wb_cyc); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant_clear got %b want 00", grant); end
        checks++; if (m0_if.wb_ack !== 1'b0) begin errors++; $display("FAIL rmid_m0_ack got %b want 0", m0_if.wb_ack); end
        checks++; if (m0_if.wb_err !== 1'b0) begin errors++; $display("FAIL rmid_m0_err got %b want 0", m0_if.wb_err); end
        tick();
        rst_n = 1;
        drive_idle();
        tick(); sample();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 0;
        drive_idle();
        test_reset();
        test_tie();
        test_single();
        test_burst();
        test_fairness();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
